// File: rtl/ham_arbiter.sv
// Two-requester, burst-granular round-robin front end for a shared HAM32 popcount
// datapath; per-word counts are summed with saturation and returned tagged by requester.

module ham32 (
  input  logic [31:0] data,
  output logic [5:0]  count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < 32; i++) count = count + 6'(data[i]);
  end

endmodule

module ham_arbiter #(
  parameter int ACCW = 16,
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [32*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ACCW-1:0]   rsp_data,
  output logic              rsp_id,
  output logic              rsp_sat
);

  typedef enum logic [1:0] {IDLE, BURST, RESP} state_t;

  state_t          state;
  logic            rr_ptr;
  logic            grant;
  logic            sat;
  logic [ACCW-1:0] acc;

  logic [31:0]     word;
  logic [5:0]      count;
  logic [ACCW:0]   acc_sum;
  logic            over;
  logic [ACCW-1:0] acc_new;
  logic            sat_new;
  logic            hs;
  logic            pick;

  assign word = req_data[32*int'(grant) +: 32];

  ham32 u_ham (
    .data  (word),
    .count (count)
  );

  // One spare bit catches overflow; a single word adds at most 32, so it cannot wrap twice.
  assign acc_sum = {1'b0, acc} + (ACCW+1)'(count);
  assign over    = acc_sum[ACCW];
  assign acc_new = over ? '1 : acc_sum[ACCW-1:0];
  assign sat_new = sat | over;

  assign hs   = req_valid[grant] & req_ready[grant];
  assign pick = (req_valid[0] & req_valid[1]) ? rr_ptr : req_valid[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      grant     <= 1'b0;
      acc       <= '0;
      sat       <= 1'b0;
      req_ready <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
      rsp_sat   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant     <= pick;
            req_ready <= NREQ'(1) << pick;
            acc       <= '0;
            sat       <= 1'b0;
            state     <= BURST;
          end
        end
        BURST: begin
          if (hs) begin
            acc <= acc_new;
            sat <= sat_new;
            if (req_last[grant]) begin
              rsp_data  <= acc_new;
              rsp_sat   <= sat_new;
              rsp_id    <= grant;
              rr_ptr    <= ~grant;
              req_ready <= '0;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
